pipe_buffer: RTL and testbench

- Parametrised elastic buffer between core pipeline stages, replacing the hand-written per-stage `_q`/`_valid_q` registers.
- Provides a valid/ready queue of configurable width and depth, with an optional combinational fall-through mode.
- Supports a full-pipeline flush and an age-based partial squash (kill) keyed on the instruction id, as needed on branch mispredict.
- Sits between fetch/decode/rename/issue: producer stage on the `in_` side, consumer stage on the `out_` side.

---
 rtl/pipe_buffer.sv | 151 +++++++++++++++
 tb/tb_pipe_buffer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_buffer.sv
// pipe_buffer: elastic valid/ready queue between pipeline stages with full flush,
// age-based suffix kill on instruction id, and optional combinational fall-through.
module pipe_buffer #(
    parameter int DATA_W      = 64,
    parameter int ID_W        = 8,
    parameter int DEPTH       = 2,
    parameter bit FALLTHROUGH = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [ID_W-1:0]            in_id,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [ID_W-1:0]            out_id,
    input  logic                       flush_i,
    input  logic                       kill_valid_i,
    input  logic [ID_W-1:0]            kill_id_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ID_W-1:0]   id_q   [DEPTH];
    logic [ID_W-1:0]   id_d   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              empty;
    logic              in_killed;
    logic              push;
    logic              pop;
    logic              bypass;
    logic              store;
    logic              found;
    logic [PTR_W-1:0]  head_after;
    logic [PTR_W-1:0]  wr_idx;
    int                remain;
    int                survivors;

    // Same age or younger than the kill id, measured on the wrapping tag.
    function automatic logic is_killed(input logic [ID_W-1:0] e, input logic v,
                                       input logic [ID_W-1:0] k);
        logic [ID_W-1:0] diff;
        diff = e - k;
        return v && !diff[ID_W-1];
    endfunction

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= DEPTH) begin
            s = s - DEPTH;
        end
        return PTR_W'(s);
    endfunction

    always_comb begin
        empty     = (count_q == '0);
        in_killed = is_killed(in_id, kill_valid_i, kill_id_i);
        in_ready  = !rst && !flush_i && (count_q < CNT_W'(DEPTH));
        if (FALLTHROUGH && empty) begin
            out_valid = !rst && in_valid && !flush_i && !in_killed;
            out_data  = in_data;
            out_id    = in_id;
        end else begin
            out_valid = !empty;
            out_data  = data_q[head_q];
            out_id    = id_q[head_q];
        end
        count_o = count_q;
    end

    // Pop is applied first; the kill then trims the remaining entries back to the
    // first killed one, and a surviving push lands directly after the survivors.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        id_d       = id_q;
        data_d     = data_q;
        push       = in_valid && in_ready;
        pop        = out_valid && out_ready && !empty;
        bypass     = FALLTHROUGH && empty && out_valid && out_ready;
        store      = 1'b0;
        found      = 1'b0;
        head_after = pop ? ptr_add(head_q, 1) : head_q;
        remain     = int'(count_q) - (pop ? 1 : 0);
        survivors  = remain;
        wr_idx     = head_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && (i < remain) &&
                    is_killed(id_q[ptr_add(head_after, i)], kill_valid_i, kill_id_i)) begin
                    survivors = i;
                    found     = 1'b1;
                end
            end
            store  = push && !bypass && !in_killed;
            wr_idx = ptr_add(head_after, survivors);
            if (store) begin
                id_d[wr_idx]   = in_id;
                data_d[wr_idx] = in_data;
            end
            head_d  = head_after;
            tail_d  = ptr_add(head_after, survivors + (store ? 1 : 0));
            count_d = CNT_W'(survivors + (store ? 1 : 0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; it is only observed while out_valid is high.
    always_ff @(posedge clk) begin
        id_q   <= id_d;
        data_q <= data_d;
    end

    logic [ID_W-1:0] last_id;
    logic [ID_W-1:0] order_diff;

    always_comb begin
        last_id    = id_q[ptr_add(tail_q, DEPTH - 1)];
        order_diff = in_id - last_id;
    end

    program_order_a : assert property (@(posedge clk) disable iff (rst)
        (store && (count_q != '0) && !kill_valid_i) |-> !order_diff[ID_W-1]);

endmodule

// File: tb/tb_pipe_buffer.sv
// Testbench for pipe_buffer: directed vector table on three configurations plus
// randomized traffic checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_pipe_buffer;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       iv   [NI];
    logic       ordy [NI];
    logic       fl   [NI];
    logic       kv   [NI];
    logic [7:0] iid  [NI];
    logic [7:0] kid  [NI];
    logic [15:0] idat [NI];
    logic       ir   [NI];
    logic       ov   [NI];
    logic [15:0] od  [NI];
    logic [7:0] oid  [NI];
    logic [1:0] cnt0;
    logic [2:0] cnt1;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_buffer #(.DATA_W(16), .ID_W(8), .DEPTH(2), .FALLTHROUGH(1'b0)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]),
        .in_id(iid[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .out_id(oid[0]), .flush_i(fl[0]), .kill_valid_i(kv[0]), .kill_id_i(kid[0]),
        .count_o(cnt0));

    pipe_buffer #(.DATA_W(16), .ID_W(8), .DEPTH(4), .FALLTHROUGH(1'b0)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
        .in_id(iid[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .out_id(oid[1]), .flush_i(fl[1]), .kill_valid_i(kv[1]), .kill_id_i(kid[1]),
        .count_o(cnt1));

    pipe_buffer #(.DATA_W(16), .ID_W(8), .DEPTH(3), .FALLTHROUGH(1'b1)) u_ft (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idat[2]),
        .in_id(iid[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
        .out_id(oid[2]), .flush_i(fl[2]), .kill_valid_i(kv[2]), .kill_id_i(kid[2]),
        .count_o(cnt2));

    typedef struct {
        int         k;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       fl;
        logic       kv;
        logic [7:0] kid;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_oid;
        int         e_cnt;
    } vec_t;

    vec_t        vecs [$];
    logic [23:0] mq   [$];

    function automatic logic [15:0] dat(input logic [7:0] id);
        return {id ^ 8'h5A, id};
    endfunction

    // Age rule from plain modular arithmetic on integers.
    function automatic bit killed_ref(input bit v, input int e, input int k);
        return v && (((((e - k) % 256) + 256) % 256) < 128);
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 4 : 3);
    endfunction

    function automatic int count_of(input int k);
        case (k)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idleAll();
        for (int k = 0; k < NI; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b0;
            fl[k]   = 1'b0;
            kv[k]   = 1'b0;
            iid[k]  = 8'h00;
            kid[k]  = 8'h00;
            idat[k] = 16'h0000;
        end
    endtask

    task automatic applyStimulus(input int k, input logic v, input logic [7:0] id,
                                 input logic [15:0] d, input logic r, input logic f,
                                 input logic kvl, input logic [7:0] kd);
        iv[k]   = v;
        iid[k]  = id;
        idat[k] = d;
        ordy[k] = r;
        fl[k]   = f;
        kv[k]   = kvl;
        kid[k]  = kd;
    endtask

    task automatic addVec(input int k, input logic v, input logic [7:0] id, input logic r,
                          input logic f, input logic kvl, input logic [7:0] kd,
                          input logic e_ir, input logic e_ov, input logic [7:0] e_oid,
                          input int e_cnt);
        vec_t t;
        t.k = k; t.iv = v; t.id = id; t.ordy = r; t.fl = f; t.kv = kvl; t.kid = kd;
        t.e_ir = e_ir; t.e_ov = e_ov; t.e_oid = e_oid; t.e_cnt = e_cnt;
        vecs.push_back(t);
    endtask

    task automatic runRow(input vec_t t, input int n);
        idleAll();
        applyStimulus(t.k, t.iv, t.id, dat(t.id), t.ordy, t.fl, t.kv, t.kid);
        #1;
        checkOutput($sformatf("row%0d in_ready", n), 32'(ir[t.k]), 32'(t.e_ir));
        checkOutput($sformatf("row%0d out_valid", n), 32'(ov[t.k]), 32'(t.e_ov));
        if (t.e_ov) begin
            checkOutput($sformatf("row%0d out_id", n), 32'(oid[t.k]), 32'(t.e_oid));
            checkOutput($sformatf("row%0d out_data", n), 32'(od[t.k]), 32'(dat(t.e_oid)));
        end
        @(posedge clk);
        #1;
        checkOutput($sformatf("row%0d count_o", n), count_of(t.k), t.e_cnt);
    endtask

    task automatic randomRun(input int k, input int ncyc);
        int          d;
        bit          ft;
        logic [7:0]  next_id;
        logic        v, r, f, kvl, do_rst, exp_ir, exp_ov, in_k, pop, bypass, push;
        logic [7:0]  kd;
        logic [15:0] rdata;
        logic [23:0] exp_head;
        logic [23:0] tmp [$];
        d  = depth_of(k);
        ft = (k == 2);
        mq.delete();
        next_id = 8'($urandom);
        for (int c = 0; c < ncyc; c++) begin
            v      = ($urandom_range(0, 3) != 0);
            r      = ($urandom_range(0, 3) != 0);
            f      = ($urandom_range(0, 39) == 0);
            kvl    = ($urandom_range(0, 19) == 0);
            kd     = next_id - 8'($urandom_range(0, 4));
            do_rst = ($urandom_range(0, 199) == 0);
            rdata  = 16'($urandom);
            idleAll();
            applyStimulus(k, v, next_id, rdata, r, f, kvl, kd);
            rst = do_rst;
            #1;
            exp_ir = !do_rst && !f && (mq.size() < d);
            in_k   = killed_ref(kvl, int'(next_id), int'(kd));
            if (ft && mq.size() == 0) begin
                exp_ov   = !do_rst && v && !f && !in_k;
                exp_head = {next_id, rdata};
            end else begin
                exp_ov   = (mq.size() != 0);
                exp_head = (mq.size() != 0) ? mq[0] : 24'h0;
            end
            checkOutput($sformatf("rnd%0d.%0d in_ready", k, c), 32'(ir[k]), 32'(exp_ir));
            checkOutput($sformatf("rnd%0d.%0d out_valid", k, c), 32'(ov[k]), 32'(exp_ov));
            if (exp_ov) begin
                checkOutput($sformatf("rnd%0d.%0d out_id", k, c), 32'(oid[k]), 32'(exp_head[23:16]));
                checkOutput($sformatf("rnd%0d.%0d out_data", k, c), 32'(od[k]), 32'(exp_head[15:0]));
            end
            if (do_rst) begin
                mq.delete();
            end else begin
                pop    = exp_ov && r;
                bypass = pop && ft && (mq.size() == 0);
                push   = v && exp_ir;
                if (f) begin
                    mq.delete();
                end else begin
                    if (pop && !bypass) begin
                        void'(mq.pop_front());
                    end
                    if (kvl) begin
                        tmp.delete();
                        foreach (mq[i]) begin
                            if (!killed_ref(1'b1, int'(mq[i][23:16]), int'(kd))) begin
                                tmp.push_back(mq[i]);
                            end
                        end
                        mq = tmp;
                    end
                    if (push && !bypass && !in_k) begin
                        mq.push_back({next_id, rdata});
                    end
                end
                if (push) begin
                    next_id = next_id + 8'd1;
                end
                if (kvl && !f) begin
                    next_id = kd;
                end
            end
            @(posedge clk);
            #1;
            checkOutput($sformatf("rnd%0d.%0d count_o", k, c), count_of(k), mq.size());
        end
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // DEPTH=2 registered stream of ids 1..8 with the consumer always ready.
        for (int t = 0; t < 8; t++) begin
            addVec(0, 1, 8'(t + 1), 1, 0, 0, 0, 1, (t != 0), 8'(t), 1);
        end
        addVec(0, 0, 0, 1, 0, 0, 0, 1, 1, 8, 0);
        // DEPTH=4 fill, backpressure and full boundary, then drain to empty.
        addVec(1, 1, 10, 0, 0, 0, 0, 1, 0, 0, 1);
        addVec(1, 1, 11, 0, 0, 0, 0, 1, 1, 10, 2);
        addVec(1, 1, 12, 0, 0, 0, 0, 1, 1, 10, 3);
        addVec(1, 1, 13, 0, 0, 0, 0, 1, 1, 10, 4);
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 1, 10, 4);
        addVec(1, 1, 14, 1, 0, 0, 0, 0, 1, 10, 3);
        addVec(1, 0, 0, 0, 0, 0, 0, 1, 1, 11, 3);
        addVec(1, 0, 0, 1, 0, 0, 0, 1, 1, 11, 2);
        addVec(1, 0, 0, 1, 0, 0, 0, 1, 1, 12, 1);
        addVec(1, 0, 0, 1, 0, 0, 0, 1, 1, 13, 0);
        addVec(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        // Kill suffix at id 22.
        addVec(1, 1, 20, 0, 0, 0, 0, 1, 0, 0, 1);
        addVec(1, 1, 21, 0, 0, 0, 0, 1, 1, 20, 2);
        addVec(1, 1, 22, 0, 0, 0, 0, 1, 1, 20, 3);
        addVec(1, 1, 23, 0, 0, 0, 0, 1, 1, 20, 4);
        addVec(1, 0, 0, 0, 0, 1, 22, 0, 1, 20, 2);
        addVec(1, 0, 0, 1, 0, 0, 0, 1, 1, 20, 1);
        addVec(1, 0, 0, 1, 0, 0, 0, 1, 1, 21, 0);
        addVec(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        // Kill across id wrap-around.
        addVec(1, 1, 254, 0, 0, 0, 0, 1, 0, 0, 1);
        addVec(1, 1, 255, 0, 0, 0, 0, 1, 1, 254, 2);
        addVec(1, 1, 0, 0, 0, 0, 0, 1, 1, 254, 3);
        addVec(1, 1, 1, 0, 0, 0, 0, 1, 1, 254, 4);
        addVec(1, 0, 0, 0, 0, 1, 255, 0, 1, 254, 1);
        addVec(1, 0, 0, 1, 0, 0, 0, 1, 1, 254, 0);
        // Pop in the kill cycle comes first; push in the kill cycle is dropped.
        addVec(1, 1, 30, 0, 0, 0, 0, 1, 0, 0, 1);
        addVec(1, 1, 31, 0, 0, 0, 0, 1, 1, 30, 2);
        addVec(1, 1, 32, 0, 0, 0, 0, 1, 1, 30, 3);
        addVec(1, 0, 0, 1, 0, 1, 30, 1, 1, 30, 0);
        addVec(1, 1, 40, 0, 0, 0, 0, 1, 0, 0, 1);
        addVec(1, 1, 41, 0, 0, 1, 41, 1, 1, 40, 1);
        addVec(1, 0, 0, 1, 0, 0, 0, 1, 1, 40, 0);
        // Flush with push and pop, and flush winning over kill.
        addVec(1, 1, 50, 0, 0, 0, 0, 1, 0, 0, 1);
        addVec(1, 1, 51, 0, 0, 0, 0, 1, 1, 50, 2);
        addVec(1, 1, 52, 0, 0, 0, 0, 1, 1, 50, 3);
        addVec(1, 1, 53, 1, 1, 0, 0, 0, 1, 50, 0);
        addVec(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        addVec(1, 1, 60, 0, 0, 0, 0, 1, 0, 0, 1);
        addVec(1, 1, 61, 0, 0, 0, 0, 1, 1, 60, 2);
        addVec(1, 0, 0, 0, 1, 1, 61, 0, 1, 60, 0);
        // Fall-through configuration.
        addVec(2, 1, 5, 1, 0, 0, 0, 1, 1, 5, 0);
        addVec(2, 1, 5, 1, 0, 1, 5, 1, 0, 0, 0);
        addVec(2, 1, 7, 0, 0, 0, 0, 1, 1, 7, 1);
        addVec(2, 1, 8, 1, 0, 0, 0, 1, 1, 7, 1);
        addVec(2, 1, 9, 1, 1, 0, 0, 0, 1, 8, 0);
        addVec(2, 1, 10, 0, 1, 0, 0, 0, 0, 0, 0);
        addVec(2, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);

        idleAll();
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("reset in_ready%0d", k), 32'(ir[k]), 32'd0);
            checkOutput($sformatf("reset out_valid%0d", k), 32'(ov[k]), 32'd0);
            checkOutput($sformatf("reset count%0d", k), count_of(k), 0);
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("release in_ready%0d", k), 32'(ir[k]), 32'd1);
        end

        foreach (vecs[n]) begin
            runRow(vecs[n], n);
        end

        randomRun(1, 1500);
        randomRun(2, 1500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
